// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle RISC-V datapath that shares one memory and one
// ALU between instruction fetch, address generation and execution. Each
// instruction walks FETCH -> DECODE -> class-specific states -> FETCH. Memory
// states wait on Mem_Ready_i. The block also counts retired instructions and
// flags illegal opcodes.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   OP_i           opcode from the instruction register (used in DECODE, MEM_ADDR)
//   Mem_Ready_i    memory finished the current read/write this cycle
//   PC_Write_o     unconditional PC load
//   Branch_o       conditional PC load (datapath qualifies with compare result)
//   IorD_o         memory address select: 0 = PC, 1 = ALUOut
//   Mem_Read_o     memory read request
//   Mem_Write_o    memory write request
//   IR_Write_o     instruction register load
//   Mem_to_Reg_o   writeback select: 00 ALUOut, 01 MDR, 10 PC
//   Reg_Write_o    register file write enable
//   ALU_Src_A_o    ALU A select: 00 PC, 01 rs1, 10 OldPC
//   ALU_Src_B_o    ALU B select: 00 rs2, 01 constant 4, 10 immediate
//   ALU_Op_o       ALU operation class (zero-extended 3-bit code)
//   PC_Src_o       PC source: 00 ALU result, 01 ALUOut
//   Illegal_o      illegal opcode detected
//   State_o        current state encoding (debug)
//   Instr_Count_o  retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_control #(
    parameter int ALU_OP_W        = 3,
    parameter int INSTR_CNT_W     = 32,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [6:0]             OP_i,
    input  logic                   Mem_Ready_i,
    output logic                   PC_Write_o,
    output logic                   Branch_o,
    output logic                   IorD_o,
    output logic                   Mem_Read_o,
    output logic                   Mem_Write_o,
    output logic                   IR_Write_o,
    output logic [1:0]             Mem_to_Reg_o,
    output logic                   Reg_Write_o,
    output logic [1:0]             ALU_Src_A_o,
    output logic [1:0]             ALU_Src_B_o,
    output logic [ALU_OP_W-1:0]    ALU_Op_o,
    output logic [1:0]             PC_Src_o,
    output logic                   Illegal_o,
    output logic [3:0]             State_o,
    output logic [INSTR_CNT_W-1:0] Instr_Count_o
);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_I      = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;

    localparam logic [2:0] ALU_R    = 3'b000;
    localparam logic [2:0] ALU_I    = 3'b001;
    localparam logic [2:0] ALU_U    = 3'b010;
    localparam logic [2:0] ALU_ADDR = 3'b011;
    localparam logic [2:0] ALU_BR   = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b110;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_I    = 4'd3,
        S_LUI       = 4'd4,
        S_ALU_WB    = 4'd5,
        S_MEM_ADDR  = 4'd6,
        S_MEM_READ  = 4'd7,
        S_MEM_WB    = 4'd8,
        S_MEM_WRITE = 4'd9,
        S_BRANCH    = 4'd10,
        S_JAL       = 4'd11,
        S_JALR      = 4'd12,
        S_ILLEGAL   = 4'd15
    } state_t;

    state_t                 state_reg;
    state_t                 state_next;
    logic [INSTR_CNT_W-1:0] count_reg;

    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       retire;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_FETCH;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (retire) begin
                count_reg <= count_reg + INSTR_CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 2'b00;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_src     = 2'b00;

        case (state_reg)
            S_FETCH: begin
                // PC+4 is computed while the instruction is read; IR and PC
                // only load on the cycle the memory delivers.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = ALU_ADD;
                ir_write  = Mem_Ready_i;
                pc_write  = Mem_Ready_i;
                if (Mem_Ready_i) begin
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Precompute OldPC + imm into ALUOut for branch/JAL targets.
                alu_src_a = 2'b10;
                alu_src_b = 2'b10;
                alu_op    = ALU_ADD;
                case (OP_i)
                    OP_R:                state_next = S_EXEC_R;
                    OP_I:                state_next = S_EXEC_I;
                    OP_LOAD, OP_STORE:   state_next = S_MEM_ADDR;
                    OP_BRANCH:           state_next = S_BRANCH;
                    OP_JAL:              state_next = S_JAL;
                    OP_JALR:             state_next = S_JALR;
                    OP_LUI:              state_next = S_LUI;
                    default:             state_next = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b00;
                alu_op     = ALU_R;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = ALU_I;
                state_next = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_b  = 2'b10;
                alu_op     = ALU_U;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b00;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = ALU_ADDR;
                state_next = (OP_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (Mem_Ready_i) begin
                    state_next = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (Mem_Ready_i) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b00;
                alu_op     = ALU_BR;
                branch     = 1'b1;
                pc_src     = 2'b01;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC already holds OldPC+4 from FETCH, so it is the link value.
                pc_write   = 1'b1;
                pc_src     = 2'b01;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_JALR: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = ALU_ADD;
                pc_src     = 2'b00;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                mem_to_reg = 2'b10;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                state_next = TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
            end
            default: begin
                // Unused encodings recover to a clean fetch.
                state_next = S_FETCH;
            end
        endcase
    end

    // Enables are masked while reset is held so nothing in the datapath
    // moves even though the FETCH decode is active.
    assign PC_Write_o    = pc_write  & reset;
    assign Branch_o      = branch    & reset;
    assign Mem_Read_o    = mem_read  & reset;
    assign Mem_Write_o   = mem_write & reset;
    assign IR_Write_o    = ir_write  & reset;
    assign Reg_Write_o   = reg_write & reset;
    assign IorD_o        = iord;
    assign Mem_to_Reg_o  = mem_to_reg;
    assign ALU_Src_A_o   = alu_src_a;
    assign ALU_Src_B_o   = alu_src_b;
    assign ALU_Op_o      = ALU_OP_W'(alu_op);
    assign PC_Src_o      = pc_src;
    assign Illegal_o     = (state_reg == S_ILLEGAL);
    assign State_o       = state_reg;
    assign Instr_Count_o = count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//
// Two instances share clock and stimulus:
//   dut_a : ALU_OP_W=3, INSTR_CNT_W=32, trap on illegal
//   dut_b : ALU_OP_W=4, INSTR_CNT_W=4,  skip illegal
// Expected behaviour is built per instruction as a list of (state, ready, op)
// steps derived from the instruction class and chosen wait counts; outputs
// per step come from the state output table.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] m2r;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
    } ctl_t;

    typedef struct {
        int         st;
        logic       rdy;
        logic [6:0] op;
    } step_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] OP_i = 7'h00;
    logic       Mem_Ready_i = 1'b0;

    logic        a_pc_write, a_branch, a_iord, a_mem_read, a_mem_write, a_ir_write;
    logic [1:0]  a_m2r, a_src_a, a_src_b, a_pc_src;
    logic        a_reg_write, a_illegal;
    logic [2:0]  a_alu_op;
    logic [3:0]  a_state;
    logic [31:0] a_count;

    logic        b_pc_write, b_branch, b_iord, b_mem_read, b_mem_write, b_ir_write;
    logic [1:0]  b_m2r, b_src_a, b_src_b, b_pc_src;
    logic        b_reg_write, b_illegal;
    logic [3:0]  b_alu_op;
    logic [3:0]  b_state;
    logic [3:0]  b_count;

    ctl_t ctl_a, ctl_b;
    assign ctl_a = {a_pc_write, a_branch, a_iord, a_mem_read, a_mem_write, a_ir_write,
                    a_m2r, a_reg_write, a_src_a, a_src_b, {1'b0, a_alu_op}, a_pc_src, a_illegal};
    assign ctl_b = {b_pc_write, b_branch, b_iord, b_mem_read, b_mem_write, b_ir_write,
                    b_m2r, b_reg_write, b_src_a, b_src_b, b_alu_op, b_pc_src, b_illegal};

    int errors = 0;
    int checks = 0;
    logic [31:0] cnt_a = 32'd0;
    logic [3:0]  cnt_b = 4'd0;

    always #5 clk = ~clk;

    multicycle_control #(.ALU_OP_W(3), .INSTR_CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .OP_i(OP_i), .Mem_Ready_i(Mem_Ready_i),
        .PC_Write_o(a_pc_write), .Branch_o(a_branch), .IorD_o(a_iord),
        .Mem_Read_o(a_mem_read), .Mem_Write_o(a_mem_write), .IR_Write_o(a_ir_write),
        .Mem_to_Reg_o(a_m2r), .Reg_Write_o(a_reg_write), .ALU_Src_A_o(a_src_a),
        .ALU_Src_B_o(a_src_b), .ALU_Op_o(a_alu_op), .PC_Src_o(a_pc_src),
        .Illegal_o(a_illegal), .State_o(a_state), .Instr_Count_o(a_count)
    );

    multicycle_control #(.ALU_OP_W(4), .INSTR_CNT_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .OP_i(OP_i), .Mem_Ready_i(Mem_Ready_i),
        .PC_Write_o(b_pc_write), .Branch_o(b_branch), .IorD_o(b_iord),
        .Mem_Read_o(b_mem_read), .Mem_Write_o(b_mem_write), .IR_Write_o(b_ir_write),
        .Mem_to_Reg_o(b_m2r), .Reg_Write_o(b_reg_write), .ALU_Src_A_o(b_src_a),
        .ALU_Src_B_o(b_src_b), .ALU_Op_o(b_alu_op), .PC_Src_o(b_pc_src),
        .Illegal_o(b_illegal), .State_o(b_state), .Instr_Count_o(b_count)
    );

    // Output table by state, straight from the state descriptions.
    function automatic ctl_t spec_outputs(input int st, input logic rdy);
        ctl_t c;
        c = '0;
        case (st)
            0:  begin c.mem_read = 1; c.src_b = 2'd1; c.alu_op = 4'd6;
                      c.ir_write = rdy; c.pc_write = rdy; end
            1:  begin c.src_a = 2'd2; c.src_b = 2'd2; c.alu_op = 4'd6; end
            2:  begin c.src_a = 2'd1; c.src_b = 2'd0; c.alu_op = 4'd0; end
            3:  begin c.src_a = 2'd1; c.src_b = 2'd2; c.alu_op = 4'd1; end
            4:  begin c.src_b = 2'd2; c.alu_op = 4'd2; end
            5:  begin c.reg_write = 1; c.m2r = 2'd0; end
            6:  begin c.src_a = 2'd1; c.src_b = 2'd2; c.alu_op = 4'd3; end
            7:  begin c.iord = 1; c.mem_read = 1; end
            8:  begin c.reg_write = 1; c.m2r = 2'd1; end
            9:  begin c.iord = 1; c.mem_write = 1; end
            10: begin c.src_a = 2'd1; c.src_b = 2'd0; c.alu_op = 4'd4;
                      c.branch = 1; c.pc_src = 2'd1; end
            11: begin c.pc_write = 1; c.pc_src = 2'd1; c.reg_write = 1; c.m2r = 2'd2; end
            12: begin c.src_a = 2'd1; c.src_b = 2'd2; c.alu_op = 4'd6; c.pc_src = 2'd0;
                      c.pc_write = 1; c.reg_write = 1; c.m2r = 2'd2; end
            15: begin c.illegal = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic step_t mk(input int st, input logic rdy, input logic [6:0] op);
        step_t s;
        s.st = st; s.rdy = rdy; s.op = op;
        return s;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    // Runs one legal instruction. fw/mw are wait cycles in fetch and the
    // data memory phase. abort_step >= 0 pulls reset during that step.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                             input int abort_step, input string tag);
        step_t plan[$];
        ctl_t  exp;
        for (int i = 0; i < fw; i++) plan.push_back(mk(0, 1'b0, rnd_op()));
        plan.push_back(mk(0, 1'b1, rnd_op()));
        plan.push_back(mk(1, rnd_bit(), op));
        case (op)
            7'h33: begin plan.push_back(mk(2, rnd_bit(), rnd_op())); plan.push_back(mk(5, rnd_bit(), rnd_op())); end
            7'h13: begin plan.push_back(mk(3, rnd_bit(), rnd_op())); plan.push_back(mk(5, rnd_bit(), rnd_op())); end
            7'h37: begin plan.push_back(mk(4, rnd_bit(), rnd_op())); plan.push_back(mk(5, rnd_bit(), rnd_op())); end
            7'h03: begin
                plan.push_back(mk(6, rnd_bit(), op));
                for (int i = 0; i < mw; i++) plan.push_back(mk(7, 1'b0, rnd_op()));
                plan.push_back(mk(7, 1'b1, rnd_op()));
                plan.push_back(mk(8, rnd_bit(), rnd_op()));
            end
            7'h23: begin
                plan.push_back(mk(6, rnd_bit(), op));
                for (int i = 0; i < mw; i++) plan.push_back(mk(9, 1'b0, rnd_op()));
                plan.push_back(mk(9, 1'b1, rnd_op()));
            end
            7'h63: plan.push_back(mk(10, rnd_bit(), rnd_op()));
            7'h6F: plan.push_back(mk(11, rnd_bit(), rnd_op()));
            7'h67: plan.push_back(mk(12, rnd_bit(), rnd_op()));
            default: plan.push_back(mk(15, rnd_bit(), rnd_op()));
        endcase

        for (int i = 0; i < plan.size(); i++) begin
            OP_i        = plan[i].op;
            Mem_Ready_i = plan[i].rdy;
            @(negedge clk);
            exp = spec_outputs(plan[i].st, plan[i].rdy);
            checks++;
            if (a_state !== 4'(plan[i].st)) begin
                errors++;
                $display("FAIL %s step%0d state_a: got %0d want %0d", tag, i, a_state, plan[i].st);
            end
            checks++;
            if (b_state !== 4'(plan[i].st)) begin
                errors++;
                $display("FAIL %s step%0d state_b: got %0d want %0d", tag, i, b_state, plan[i].st);
            end
            checks++;
            if (ctl_a !== exp) begin
                errors++;
                $display("FAIL %s step%0d ctl_a: got %05h want %05h", tag, i, ctl_a, exp);
            end
            checks++;
            if (ctl_b !== exp) begin
                errors++;
                $display("FAIL %s step%0d ctl_b: got %05h want %05h", tag, i, ctl_b, exp);
            end
            checks++;
            if (a_count !== cnt_a) begin
                errors++;
                $display("FAIL %s step%0d count_a: got %0d want %0d", tag, i, a_count, cnt_a);
            end
            checks++;
            if (b_count !== cnt_b) begin
                errors++;
                $display("FAIL %s step%0d count_b: got %0d want %0d", tag, i, b_count, cnt_b);
            end

            if (i == abort_step) begin
                #2 reset = 1'b0;
                #1;
                exp = spec_outputs(0, Mem_Ready_i);
                exp.pc_write = 0; exp.branch = 0; exp.mem_read = 0;
                exp.mem_write = 0; exp.ir_write = 0; exp.reg_write = 0;
                checks++;
                if (a_state !== 4'd0 || b_state !== 4'd0) begin
                    errors++;
                    $display("FAIL %s abort_state: got %0d/%0d want 0", tag, a_state, b_state);
                end
                checks++;
                if (ctl_a !== exp || ctl_b !== exp) begin
                    errors++;
                    $display("FAIL %s abort_ctl: got %05h/%05h want %05h", tag, ctl_a, ctl_b, exp);
                end
                checks++;
                if (a_count !== 32'd0 || b_count !== 4'd0) begin
                    errors++;
                    $display("FAIL %s abort_count: got %0d/%0d want 0", tag, a_count, b_count);
                end
                cnt_a = 32'd0;
                cnt_b = 4'd0;
                @(posedge clk);
                #1 reset = 1'b1;
                $display("txn %s op=%02h aborted at step %0d", tag, op, i);
                return;
            end
            @(posedge clk);
            #1;
        end
        cnt_a = cnt_a + 32'd1;
        cnt_b = cnt_b + 4'd1;
        $display("txn %s op=%02h fw=%0d mw=%0d cycles=%0d cnt_a=%0d", tag, op, fw, mw, plan.size(), cnt_a);
    endtask

    task automatic test_reset();
        ctl_t exp;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp = spec_outputs(0, Mem_Ready_i);
        exp.pc_write = 0; exp.branch = 0; exp.mem_read = 0;
        exp.mem_write = 0; exp.ir_write = 0; exp.reg_write = 0;
        checks++;
        if (a_state !== 4'd0 || b_state !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d/%0d want 0", a_state, b_state);
        end
        checks++;
        if (ctl_a !== exp || ctl_b !== exp) begin
            errors++;
            $display("FAIL reset_ctl: got %05h/%05h want %05h", ctl_a, ctl_b, exp);
        end
        checks++;
        if (a_count !== 32'd0 || b_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d/%0d want 0", a_count, b_count);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        $display("txn reset released");
    endtask

    task automatic test_r_type();
        run_instr(7'h33, 0, 0, -1, "r_type");
    endtask

    task automatic test_load_wait();
        run_instr(7'h03, 0, 3, -1, "load_wait");
    endtask

    task automatic test_store();
        run_instr(7'h23, 0, 0, -1, "store");
    endtask

    task automatic test_branch_jal();
        run_instr(7'h63, 0, 0, -1, "branch");
        run_instr(7'h6F, 0, 0, -1, "jal");
    endtask

    task automatic test_random();
        logic [6:0] legal [8];
        legal = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};
        for (int n = 0; n < 40; n++) begin
            run_instr(legal[$urandom_range(0, 7)], int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), -1, "random");
        end
    endtask

    task automatic test_wrap();
        #3 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        cnt_a = 32'd0;
        cnt_b = 4'd0;
        for (int n = 0; n < 16; n++) run_instr(7'h33, 0, 0, -1, "wrap");
        @(negedge clk);
        checks++;
        if (a_count !== 32'd16) begin
            errors++;
            $display("FAIL wrap_count_a: got %0d want 16", a_count);
        end
        checks++;
        if (b_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_count_b: got %0d want 0", b_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        // Steps: F, D, MEM_ADDR, then MEM_READ waits; abort in the 2nd wait.
        run_instr(7'h03, 0, 3, 4, "reset_mid_op");
    endtask

    task automatic test_illegal();
        int st_a, st_b;
        ctl_t ea, eb;
        OP_i        = 7'h7F;
        Mem_Ready_i = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            st_a = (k == 0) ? 0 : (k == 1) ? 1 : 15;
            st_b = (k % 3 == 0) ? 0 : (k % 3 == 1) ? 1 : 15;
            ea = spec_outputs(st_a, 1'b1);
            eb = spec_outputs(st_b, 1'b1);
            checks++;
            if (a_state !== 4'(st_a) || a_illegal !== ea.illegal) begin
                errors++;
                $display("FAIL illegal_trap c%0d: state %0d ill %0b want %0d %0b", k, a_state, a_illegal, st_a, ea.illegal);
            end
            checks++;
            if (b_state !== 4'(st_b) || b_illegal !== eb.illegal) begin
                errors++;
                $display("FAIL illegal_skip c%0d: state %0d ill %0b want %0d %0b", k, b_state, b_illegal, st_b, eb.illegal);
            end
            checks++;
            if (ctl_a !== ea || ctl_b !== eb) begin
                errors++;
                $display("FAIL illegal_ctl c%0d: got %05h/%05h want %05h/%05h", k, ctl_a, ctl_b, ea, eb);
            end
            checks++;
            if (a_count !== cnt_a || b_count !== cnt_b) begin
                errors++;
                $display("FAIL illegal_count c%0d: got %0d/%0d want %0d/%0d", k, a_count, b_count, cnt_a, cnt_b);
            end
            @(posedge clk);
            #1;
        end
        $display("txn illegal op=7f cycles=12 cnt_a=%0d cnt_b=%0d", cnt_a, cnt_b);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_r_type();
        test_load_wait();
        test_store();
        test_branch_jal();
        test_random();
        test_wrap();
        test_reset_mid_op();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
